// File: rtl/mic_frame_capture_if.sv
//------------------------------------------------------------------------------
// mic_frame_capture_if
//   Bundles the ADC pins, consumer controls and published frame of
//   mic_frame_capture into one port.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mic_frame_capture_if #(
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 64
);
   logic                enable;
   logic                mic_sd;
   logic                frame_hold;
   logic                mic_sck;
   logic                mic_cs_n;
   logic [SAMPLE_W-1:0] frame_out [DEPTH];
   logic                frame_valid;
   logic [7:0]          overrun_count;

   modport master (
      output enable, mic_sd, frame_hold,
      input  mic_sck, mic_cs_n, frame_out, frame_valid, overrun_count
   );

   modport slave (
      input  enable, mic_sd, frame_hold,
      output mic_sck, mic_cs_n, frame_out, frame_valid, overrun_count
   );
endinterface

`default_nettype wire

// File: rtl/mic_frame_capture.sv
//------------------------------------------------------------------------------
// mic_frame_capture
//   Serial ADC reader that assembles DEPTH-sample frames in a shadow buffer
//   and publishes each complete frame atomically unless the consumer holds.
//   Optional feature macro: MIC_OVERRUN_CNT_EN (saturating dropped-frame count).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mic_frame_capture #(
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 64,
   parameter int SCK_HALF = 25,
   parameter int GAP_CLKS = 8
) (
   input  wire                  clk,
   input  wire                  reset,
   mic_frame_capture_if.slave   bus
);

   localparam int DIV_W = $clog2(SCK_HALF);
   localparam int BIT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
   localparam int GAP_W = $clog2(GAP_CLKS + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_STORE   = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   state_t              state_q;
   logic                sd_meta_q;
   logic                sd_sync_q;
   logic                sck_q;
   logic                cs_n_q;
   logic [DIV_W-1:0]    div_q;
   logic [BIT_W-1:0]    bit_q;
   logic [GAP_W-1:0]    gap_q;
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [SAMPLE_W-1:0] shift_q;
   logic [SAMPLE_W-1:0] shift_d;
   logic                frame_valid_q;
   logic [SAMPLE_W-1:0] shadow_q  [DEPTH];
   logic [SAMPLE_W-1:0] frame_q   [DEPTH];
   logic [SAMPLE_W-1:0] publish_d [DEPTH];

   assign shift_d = {shift_q[SAMPLE_W-2:0], sd_sync_q};

   // The published image must include the word being written this cycle.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         publish_d[i] = (PTR_W'(i) == wr_ptr_q) ? shift_q : shadow_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         sd_meta_q     <= 1'b0;
         sd_sync_q     <= 1'b0;
         sck_q         <= 1'b0;
         cs_n_q        <= 1'b1;
         div_q         <= '0;
         bit_q         <= '0;
         gap_q         <= '0;
         wr_ptr_q      <= '0;
         shift_q       <= '0;
         frame_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            frame_q[i] <= '0;
         end
      end else begin
         sd_meta_q     <= bus.mic_sd;
         sd_sync_q     <= sd_meta_q;
         frame_valid_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (bus.enable) begin
                  state_q <= ST_CONVERT;
                  cs_n_q  <= 1'b0;
                  sck_q   <= 1'b0;
                  div_q   <= '0;
                  bit_q   <= '0;
               end
            end

            ST_CONVERT: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  sck_q <= ~sck_q;
                  if (sck_q) begin
                     shift_q <= shift_d;
                     bit_q   <= bit_q + 1'b1;
                     if (bit_q == BIT_LAST) begin
                        cs_n_q  <= 1'b1;
                        state_q <= ST_STORE;
                     end
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            ST_STORE: begin
               shadow_q[wr_ptr_q] <= shift_q;
               wr_ptr_q           <= wr_ptr_q + 1'b1;
               if ((wr_ptr_q == PTR_LAST) && !bus.frame_hold) begin
                  frame_q       <= publish_d;
                  frame_valid_q <= 1'b1;
               end
               gap_q   <= '0;
               state_q <= ST_GAP;
            end

            ST_GAP: begin
               // Counting 0..GAP_CLKS adds the restart cycle, so the
               // conversion period is 2*SCK_HALF*SAMPLE_W + GAP_CLKS + 2.
               if (gap_q == GAP_LAST) begin
                  if (bus.enable) begin
                     state_q <= ST_CONVERT;
                     cs_n_q  <= 1'b0;
                     sck_q   <= 1'b0;
                     div_q   <= '0;
                     bit_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.mic_sck     = sck_q;
   assign bus.mic_cs_n    = cs_n_q;
   assign bus.frame_out   = frame_q;
   assign bus.frame_valid = frame_valid_q;

`ifdef MIC_OVERRUN_CNT_EN
   logic       drop_w;
   logic [7:0] overrun_q;

   assign drop_w = (state_q == ST_STORE) && (wr_ptr_q == PTR_LAST) && bus.frame_hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_q <= 8'd0;
      end else if (drop_w && (overrun_q != 8'hFF)) begin
         overrun_q <= overrun_q + 8'd1;
      end
   end

   assign bus.overrun_count = overrun_q;
`else
   assign bus.overrun_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mic_frame_capture.sv
// Randomised/directed bench for mic_frame_capture with a behavioural frame model
// and per-cycle output comparison.
`default_nettype none

module tb_mic_frame_capture;
   localparam int SW        = 16;
   localparam int DP        = 16;
   localparam int SH        = 3;
   localparam int GC        = 2;
   localparam int CONV_CLKS = 2 * SH * SW;            // 96
   localparam int PERIOD    = CONV_CLKS + 1 + GC + 1; // 100
`ifdef MIC_OVERRUN_CNT_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   mic_frame_capture_if #(.SAMPLE_W(SW), .DEPTH(DP)) bus ();

   mic_frame_capture #(
      .SAMPLE_W(SW), .DEPTH(DP), .SCK_HALF(SH), .GAP_CLKS(GC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
         if (errors >= 100) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   endtask

   // ADC model: launches MSB-first on each rising mic_sck while selected
   int          mode    = 0;
   logic [15:0] inc_val = 16'd0;
   logic [15:0] conv_val = 16'd0;

   initial begin
      logic d_cs_prev;
      logic d_sck_prev;
      int   bitn;
      d_cs_prev  = 1'b1;
      d_sck_prev = 1'b0;
      bitn       = 0;
      bus.mic_sd = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (d_cs_prev && !bus.mic_cs_n) begin
            bitn = 0;
            case (mode)
               0:       conv_val = 16'hA5C3;
               1: begin conv_val = inc_val; inc_val = inc_val + 16'd1; end
               default: conv_val = 16'($urandom);
            endcase
         end
         if (!bus.mic_cs_n && bus.mic_sck && !d_sck_prev && bitn < SW) begin
            bus.mic_sd = conv_val[SW-1-bitn];
            bitn = bitn + 1;
         end
         d_cs_prev  = bus.mic_cs_n;
         d_sck_prev = bus.mic_sck;
      end
   end

   // Behavioural model and per-cycle compare
   logic [15:0] m_shadow   [DP];
   logic [15:0] m_frame    [DP];
   logic [15:0] pend_frame [DP];
   bit   pend_pub, pend_drop, m_valid;
   int   m_ptr, m_ovr;
   int   comp_count = 0;
   int   conv_started = 0;
   int   conv_done = 0;
   int   last_fall = -1;
   int   first_fall = -1;
   int   sck_rises, sck_falls;
   bit   en_low = 1'b1;
   logic cs_prev = 1'b1;
   logic sck_prev = 1'b0;

   initial begin
      int bad;
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int i = 0; i < DP; i++) begin
               m_shadow[i] = '0;
               m_frame[i]  = '0;
            end
            pend_pub = 0; pend_drop = 0; m_valid = 0;
            m_ptr = 0; m_ovr = 0;
            conv_started = 0; conv_done = 0;
            last_fall = -1; first_fall = -1;
            en_low = 1'b1; cs_prev = 1'b1; sck_prev = 1'b0;
         end else begin
            m_valid = pend_pub;
            if (pend_pub) m_frame = pend_frame;
            if (pend_drop && OVR_EN && m_ovr < 255) m_ovr = m_ovr + 1;
            pend_pub = 0; pend_drop = 0;

            chk("frame_valid", 32'(bus.frame_valid), 32'(m_valid));
            chk("overrun_count", 32'(bus.overrun_count), 32'(m_ovr));
            bad = -1;
            for (int i = 0; i < DP; i++)
               if (bus.frame_out[i] !== m_frame[i] && bad < 0) bad = i;
            if (bad >= 0) chk($sformatf("frame_out[%0d]", bad), 32'(bus.frame_out[bad]), 32'(m_frame[bad]));
            else chk("frame_out", 32'd0, 32'd0 + 32'(bad + 1));
            if (bus.mic_cs_n) chk("sck_idle_low", 32'(bus.mic_sck), 32'd0);

            if (!bus.enable) en_low = 1'b1;

            if (cs_prev && !bus.mic_cs_n) begin
               conv_started = conv_started + 1;
               if (first_fall < 0) first_fall = cyc;
               if (!en_low && last_fall >= 0) chk("conversion_period", 32'(cyc - last_fall), PERIOD);
               last_fall = cyc;
               en_low = 1'b0;
               sck_rises = 0; sck_falls = 0;
            end
            if (!cs_prev) begin
               if (bus.mic_sck && !sck_prev) begin
                  sck_rises = sck_rises + 1;
                  chk("sck_rise_time", 32'(cyc - last_fall), 32'((2 * sck_rises - 1) * SH));
               end
               if (!bus.mic_sck && sck_prev) begin
                  sck_falls = sck_falls + 1;
                  chk("sck_fall_time", 32'(cyc - last_fall), 32'(2 * sck_falls * SH));
               end
            end
            if (!cs_prev && bus.mic_cs_n) begin
               // STORE cycle: the DUT commits at the next edge
               conv_done = conv_done + 1;
               chk("sck_pulses", 32'(sck_falls), SW);
               chk("convert_length", 32'(cyc - last_fall), CONV_CLKS);
               m_shadow[m_ptr] = conv_val;
               if (m_ptr == DP - 1) begin
                  comp_count = comp_count + 1;
                  if (bus.frame_hold) pend_drop = 1;
                  else begin
                     pend_pub = 1;
                     pend_frame = m_shadow;
                  end
               end
               m_ptr = (m_ptr + 1) % DP;
            end
            cs_prev  = bus.mic_cs_n;
            sck_prev = bus.mic_sck;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) step();
   endtask

   task automatic wait_valid(input string name, input int budget, output int at);
      bit found;
      found = 0;
      at = -1;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (bus.frame_valid === 1'b1) begin
            found = 1;
            at = cyc;
         end
      end
      if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_comp(input int target, input int budget);
      int n;
      n = 0;
      while (comp_count < target && n < budget) begin
         step();
         n = n + 1;
      end
      if (comp_count < target) chk("frame_completion_timeout", 32'(comp_count), 32'(target));
   endtask

   int cyc_en, t, c0, lows, n;

   initial begin
      bus.enable     = 1'b0;
      bus.frame_hold = 1'b0;
      reset          = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      @(negedge clk);
      chk("reset_cs_n", 32'(bus.mic_cs_n), 32'd1);
      chk("reset_sck", 32'(bus.mic_sck), 32'd0);
      chk("reset_frame_valid", 32'(bus.frame_valid), 32'd0);
      chk("reset_overrun", 32'(bus.overrun_count), 32'd0);
      chk("reset_frame_out0", 32'(bus.frame_out[0]), 32'd0);

      // Constant-sample frame
      mode = 0;
      step();
      bus.enable = 1'b1;
      cyc_en = cyc;
      wait_valid("first_frame", 2000, t);
      chk("cs_fall_after_enable", 32'(first_fall - cyc_en), 32'd1);
      chk("first_valid_latency", 32'(t - cyc_en), 32'd1598);
      chk("const_frame_out0", 32'(bus.frame_out[0]), 32'hA5C3);
      chk("const_frame_out_last", 32'(bus.frame_out[DP-1]), 32'hA5C3);

      // Incrementing samples from idle
      step();
      bus.enable = 1'b0;
      wait_cyc(PERIOD + 10);
      mode = 1;
      inc_val = 16'd0;
      bus.enable = 1'b1;
      wait_valid("inc_frame1", 2000, t);
      chk("inc_frame_out0", 32'(bus.frame_out[0]), 32'd0);
      chk("inc_frame_out5", 32'(bus.frame_out[5]), 32'd5);
      chk("inc_frame_out15", 32'(bus.frame_out[15]), 32'd15);
      wait_valid("inc_frame2", 2000, t);
      chk("inc2_frame_out0", 32'(bus.frame_out[0]), 32'd16);
      chk("inc2_frame_out15", 32'(bus.frame_out[15]), 32'd31);

      // Hold across two completions
      step();
      bus.frame_hold = 1'b1;
      c0 = comp_count;
      wait_comp(c0 + 2, 4000);
      wait_cyc(3);
      chk("hold_overrun", 32'(bus.overrun_count), OVR_EN ? 32'd2 : 32'd0);
      chk("hold_frame_out0", 32'(bus.frame_out[0]), 32'd16);
      bus.frame_hold = 1'b0;
      wait_valid("after_hold", 2000, t);
      chk("after_hold_frame_out0", 32'(bus.frame_out[0]), 32'd64);
      chk("after_hold_frame_out15", 32'(bus.frame_out[15]), 32'd79);

      // Reset during bit 7 of a conversion
      n = 0;
      step();
      while (bus.mic_cs_n !== 1'b0 && n < 500) begin
         step();
         n = n + 1;
      end
      wait_cyc(44);
      reset = 1'b1;
      inc_val = 16'd0;
      @(negedge clk);
      @(negedge clk);
      chk("midreset_cs_n", 32'(bus.mic_cs_n), 32'd1);
      chk("midreset_sck", 32'(bus.mic_sck), 32'd0);
      chk("midreset_frame_out0", 32'(bus.frame_out[0]), 32'd0);
      chk("midreset_frame_out_last", 32'(bus.frame_out[DP-1]), 32'd0);
      step();
      reset = 1'b0;

      // Drop enable halfway through sample 10
      n = 0;
      while (conv_started < 11 && n < 2000) begin
         step();
         n = n + 1;
      end
      chk("sample10_started", 32'(conv_started), 32'd11);
      wait_cyc(48);
      bus.enable = 1'b0;
      wait_cyc(PERIOD);
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.mic_cs_n !== 1'b1) lows = lows + 1;
      end
      chk("idle_cs_n_low_cycles", 32'(lows), 32'd0);
      chk("samples_before_idle", 32'(conv_done), 32'd11);
      bus.enable = 1'b1;
      wait_valid("reenable_frame", 2000, t);
      chk("reenable_frame_out10", 32'(bus.frame_out[10]), 32'd10);
      chk("reenable_frame_out11", 32'(bus.frame_out[11]), 32'd11);
      chk("reenable_frame_out15", 32'(bus.frame_out[15]), 32'd15);

      // Random samples with random hold per frame
      mode = 2;
      for (int r = 0; r < 5; r++) begin
         step();
         bus.frame_hold = 1'($urandom_range(0, 1));
         wait_comp(comp_count + 1, 2000);
      end
      step();
      bus.frame_hold = 1'b0;
      bus.enable = 1'b0;
      wait_cyc(2 * PERIOD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
